axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - Round-robin arbiter funnelling fetch and load reads onto one AXI read master.
// One transaction in flight; single-beat reads only.
module axi_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_instr,
    output logic              if_rsp_err,

    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [2:0]        ls_req_size,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic              protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AREQ  = 2'd1,
        S_RWAIT = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_size;
    logic                r_if_rsp_valid;
    logic [31:0]         r_if_rsp_instr;
    logic                r_if_rsp_err;
    logic                r_ls_rsp_valid;
    logic [DATA_W-1:0]   r_ls_rsp_data;
    logic                r_ls_rsp_err;
    logic                r_protocol_err;

    logic                w_grant_ls;
    logic                w_if_ready;
    logic                w_ls_ready;
    logic                w_accept;
    logic                w_match;
    logic                w_rsp_fire;
    logic                w_bad_beat;
    logic                w_in_areq;
    logic [2:0]          w_ls_size_clamped;

    // With both requesters valid, the one not granted last time wins.
    assign w_grant_ls        = ls_req_valid & (~if_req_valid | (r_last_grant == OWN_IF));
    assign w_match           = rlast & (rid == {3'b000, r_owner});
    assign w_ls_size_clamped = ls_req_size[2] ? 3'b011 : ls_req_size;
    assign w_accept          = w_if_ready | w_ls_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_if_ready  = 1'b0;
        w_ls_ready  = 1'b0;
        w_rsp_fire  = 1'b0;
        w_bad_beat  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_if_ready = if_req_valid & ~w_grant_ls;
                w_ls_ready = w_grant_ls;
                if (w_if_ready | w_ls_ready) begin
                    w_state_nxt = S_AREQ;
                end
            end
            S_AREQ: begin
                if (arready) begin
                    w_state_nxt = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (rvalid) begin
                    if (w_match) begin
                        w_rsp_fire  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bad_beat = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant   <= OWN_IF;
            r_owner        <= OWN_IF;
            r_addr         <= '0;
            r_size         <= 3'b000;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_instr <= 32'd0;
            r_if_rsp_err   <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            r_ls_rsp_data  <= '0;
            r_ls_rsp_err   <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_if_rsp_valid <= w_rsp_fire & (r_owner == OWN_IF);
            r_ls_rsp_valid <= w_rsp_fire & (r_owner == OWN_LS);
            if (w_accept) begin
                r_owner      <= w_ls_ready;
                r_last_grant <= w_ls_ready;
                r_addr       <= w_ls_ready ? ls_req_addr : if_req_addr;
                r_size       <= w_ls_ready ? w_ls_size_clamped : 3'b010;
            end
            // Fetch returns the 32-bit word selected by address bit 2.
            if (w_rsp_fire && r_owner == OWN_IF) begin
                r_if_rsp_instr <= r_addr[2] ? rdata[63:32] : rdata[31:0];
                r_if_rsp_err   <= (rresp != 2'b00);
            end
            if (w_rsp_fire && r_owner == OWN_LS) begin
                r_ls_rsp_data <= rdata;
                r_ls_rsp_err  <= (rresp != 2'b00);
            end
            if (w_bad_beat) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // AR fields read zero outside AREQ and are held from capture registers inside it.
    assign w_in_areq = (r_state == S_AREQ);
    assign arvalid   = w_in_areq;
    assign arid      = w_in_areq ? {3'b000, r_owner} : 4'd0;
    assign araddr    = w_in_areq ? r_addr : '0;
    assign arlen     = 8'd0;
    assign arsize    = w_in_areq ? r_size : 3'b000;
    assign arburst   = w_in_areq ? 2'b01 : 2'b00;
    assign arprot    = (w_in_areq && r_owner == OWN_IF) ? 3'b100 : 3'b000;
    assign rready    = (r_state == S_RWAIT);

    assign if_req_ready = w_if_ready;
    assign ls_req_ready = w_ls_ready;
    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_instr = r_if_rsp_instr;
    assign if_rsp_err   = r_if_rsp_err;
    assign ls_rsp_valid = r_ls_rsp_valid;
    assign ls_rsp_data  = r_ls_rsp_data;
    assign ls_rsp_err   = r_ls_rsp_err;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_instr;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic [63:0] ls_req_addr;
    logic [2:0]  ls_req_size;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic [3:0]  arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        protocol_err;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_ls;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_size(ls_req_size),
        .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .ls_rsp_err(ls_rsp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .protocol_err(protocol_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_size = 3'b000;
        arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_ar_fields", {arid, araddr, arlen, arsize, arburst, arprot}, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp", {if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err, protocol_err}, 0);
        step();
        rst = 1'b0;

        // Single fetch, immediate ARREADY and R beat
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0004; arready = 1'b1;
        @(negedge clk);
        chk("t1_if_ready", if_req_ready, 1);
        chk("t1_ls_ready", ls_req_ready, 0);
        step();
        if_req_valid = 1'b0; if_req_addr = '0;
        @(negedge clk);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 64'h8000_0004);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 2);
        chk("t1_arprot", arprot, 3'b100);
        chk("t1_arburst_arlen", {arburst, arlen}, {2'b01, 8'd0});
        step();
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 64'h1111_2222_3333_4444; rresp = 2'b00;
        @(negedge clk);
        chk("t1_rwait_arvalid", arvalid, 0);
        chk("t1_rready", rready, 1);
        chk("t1_early_rsp", if_rsp_valid, 0);
        step();
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        chk("t1_rsp_valid", if_rsp_valid, 1);
        chk("t1_rsp_instr", if_rsp_instr, 32'h1111_2222);
        chk("t1_rsp_err", if_rsp_err, 0);
        chk("t1_rready_idle", rready, 0);
        step();
        @(negedge clk);
        chk("t1_rsp_pulse_end", if_rsp_valid, 0);

        // Both requesters after reset: LS first, then alternate
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'h100;
        ls_req_valid = 1'b1; ls_req_addr = 64'h200; ls_req_size = 3'b011;
        @(negedge clk);
        chk("t2_ls_ready_0", ls_req_ready, 1);
        chk("t2_if_ready_0", if_req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            exp_ls = (k % 2 == 0);
            step();
            @(negedge clk);
            chk("t2_arid", arid, {3'b000, exp_ls});
            chk("t2_arprot", arprot, exp_ls ? 3'b000 : 3'b100);
            chk("t2_araddr", araddr, exp_ls ? 64'h200 : 64'h100);
            step();
            rvalid = 1'b1; rid = {3'b000, exp_ls}; rlast = 1'b1; rdata = 64'h0123_4567_89AB_CDEF + 64'(k);
            step();
            rvalid = 1'b0; rlast = 1'b0;
            @(negedge clk);
            chk("t2_rsp_owner", {ls_rsp_valid, if_rsp_valid}, exp_ls ? 2'b10 : 2'b01);
            if (k < 3) begin
                chk("t2_regrant_ls", ls_req_ready, !exp_ls);
                chk("t2_regrant_if", if_req_ready, exp_ls);
            end
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;

        // AR stall for 5 cycles, size clamp, error response
        step();
        arready = 1'b0;
        ls_req_valid = 1'b1; ls_req_addr = 64'h1000; ls_req_size = 3'b110;
        @(negedge clk);
        chk("t3_ls_ready", ls_req_ready, 1);
        step();
        ls_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 64'h40;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_arvalid", arvalid, 1);
            chk("t3_stall_fields", {arid, araddr, arsize, arburst}, {4'd1, 64'h1000, 3'b011, 2'b01});
            chk("t3_stall_no_ready", {if_req_ready, ls_req_ready}, 0);
            step();
        end
        arready = 1'b1; if_req_valid = 1'b0;
        @(negedge clk);
        chk("t3_arvalid_held", arvalid, 1);
        step();
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; rresp = 2'b10; rdata = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        @(negedge clk);
        chk("t3_ls_rsp_valid", ls_rsp_valid, 1);
        chk("t3_ls_rsp_err", ls_rsp_err, 1);
        chk("t3_ls_rsp_data", ls_rsp_data, 64'hDEAD_BEEF_CAFE_F00D);

        // Wrong-ID beat while fetch outstanding
        step();
        if_req_valid = 1'b1; if_req_addr = 64'h0;
        @(negedge clk);
        chk("t4_if_ready", if_req_ready, 1);
        step();
        if_req_valid = 1'b0;
        step();
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; rdata = 64'h5555_6666_7777_8888;
        step();
        rid = 4'd0; rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        chk("t4_protocol_err", protocol_err, 1);
        chk("t4_no_rsp", if_rsp_valid, 0);
        chk("t4_still_rwait", rready, 1);
        step();
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        chk("t4_rsp_valid", if_rsp_valid, 1);
        chk("t4_rsp_instr", if_rsp_instr, 32'hCCCC_DDDD);
        chk("t4_err_sticky", protocol_err, 1);

        // Reset during RWAIT, then a late beat
        step();
        if_req_valid = 1'b1; if_req_addr = 64'h8;
        step();
        if_req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t5_in_rwait", rready, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_rready", rready, 0);
        chk("t5_rst_protocol_err", protocol_err, 0);
        step();
        rst = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 64'h9999_9999_9999_9999;
        @(negedge clk);
        chk("t5_late_rready", rready, 0);
        step();
        @(negedge clk);
        chk("t5_late_no_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        chk("t5_late_no_err", protocol_err, 0);
        step();
        rvalid = 1'b0; rlast = 1'b0;
        if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_req_size = 3'b011;
        @(negedge clk);
        chk("t5_idle_ls_ready", ls_req_ready, 1);
        chk("t5_idle_if_ready", if_req_ready, 0);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t5_idle_no_arvalid", arvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
